matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter PRECISION, default 32, word width of each IEEE-754 matrix element.
REQ-002 SHALL have parameter TIMEOUT, default 1024, max cycles to wait for sigma_valid (used only under REQ-030).
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports s_tdata  input  PRECISION, s_tvalid  input  1, s_tready  output  1, s_tlast  input  1: element stream, row-major A00..A22.
REQ-006 SHALL have ports A00..A22  output  PRECISION each: nine registered matrix elements for the sigma stage.
REQ-007 SHALL have port tvalid  output  1: one-cycle start pulse to the sigma stage.
REQ-008 SHALL have port sigma_valid  input  1: sigma stage result-valid.
REQ-009 SHALL have ports busy  output  1 (matrix in flight) and frame_err  output  1 (one-cycle pulse).

Function
REQ-010 SHALL implement states LOAD, FIRE, WAIT.
REQ-011 SHALL accept a word when s_tvalid && s_tready; s_tready SHALL be 1 only in LOAD.
REQ-012 SHALL keep a 4-bit index 0..8; accepted word at index k SHALL be written to element k (0=A00, 1=A01, 2=A02, 3=A10, ... 8=A22) and index incremented.
REQ-013 On accepting index 8 with s_tlast=1, SHALL reset index to 0 and go LOAD->FIRE.
REQ-014 If s_tlast=1 on index 0..7, or s_tlast=0 on index 8, SHALL pulse frame_err for one cycle, reset index to 0, stay in LOAD; partially written elements are don't-care.
REQ-015 In FIRE, SHALL assert tvalid for exactly one cycle and go to WAIT unconditionally.
REQ-016 A00..A22 SHALL be stable from the FIRE cycle until WAIT exits.
REQ-017 In WAIT, on sigma_valid=1, SHALL go to LOAD; s_tready rises the cycle after.
REQ-018 sigma_valid SHALL be ignored in LOAD and FIRE.
REQ-019 busy SHALL be 1 in FIRE and WAIT, 0 in LOAD.
REQ-020 Latency from last-word accept to tvalid SHALL be exactly 1 cycle.
REQ-021 Back-to-back: next matrix's first word SHALL be accepted no earlier than the cycle after sigma_valid is sampled in WAIT.
REQ-022 All outputs SHALL be registered; no combinational input-to-output path except none.

Reset
REQ-023 Reset SHALL force state LOAD, index 0, A00..A22=0, tvalid=0, busy=0, frame_err=0, timeout=0.
REQ-024 s_tready SHALL be 0 while reset is asserted and 1 the first cycle after deassertion.
REQ-025 Reset asserted mid-load or mid-WAIT SHALL discard the matrix and suppress any pending tvalid.

Configuration
REQ-030 With MATRIX_LOADER_TIMEOUT_EN defined: SHALL add output timeout  1  (one-cycle pulse) and a WAIT-cycle counter; if sigma_valid is not seen within TIMEOUT cycles of entering WAIT, SHALL pulse timeout and return to LOAD.
REQ-031 Without MATRIX_LOADER_TIMEOUT_EN: no timeout port or counter; WAIT SHALL persist until sigma_valid or reset.

Structure
REQ-040 Shared package matrix_pkg SHALL hold the state enum (LOAD, FIRE, WAIT), N_ELEM=9, LAST_IDX=8.
REQ-041 No sub-module; single module with state register, index counter, element register bank.

Verification
REQ-050 Stream 0, 3f000000, 3d4ccccd, 3eaaaaaa, 0, 3eaaaaaa, 3d4ccccd, 3f000000, 0 (tlast on 9th) -> A01=3f000000, A12=3eaaaaaa, A20=3d4ccccd; tvalid high exactly 1 cycle, 1 cycle after last accept.
REQ-051 tlast on 5th word -> frame_err one pulse, no tvalid; following good 9-word frame loads correctly.
REQ-052 s_tvalid held high in WAIT for 20 cycles, sigma_valid pulsed on cycle 20 -> s_tready=0 throughout, A regs unchanged, s_tready=1 cycle 21.
REQ-053 Reset asserted after 4 words, released, 9 new words sent -> only new values appear, one tvalid.
REQ-054 Two matrices back-to-back with sigma_valid 1 cycle after tvalid -> two tvalid pulses, second matrix intact.
REQ-055 With MATRIX_LOADER_TIMEOUT_EN, TIMEOUT=16, no sigma_valid -> timeout pulse 16 cycles after WAIT entry, s_tready=1 next cycle.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and sizes for the 3x3 matrix loader feeding the sigma stage.
package matrix_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FIRE = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int N_ELEM   = 9;
    localparam int LAST_IDX = 8;

    localparam logic [3:0] IDX_LAST = 4'(LAST_IDX);

endpackage

// File: rtl/matrix_loader.sv
// Collects a row-major 3x3 element stream, fires the sigma stage and waits for its result.
// Optional WAIT watchdog enabled by defining MATRIX_LOADER_TIMEOUT_EN.
//
// state | meaning
// LOAD  | accepting elements A00..A22, s_tready high
// FIRE  | one-cycle tvalid start pulse, elements frozen
// WAIT  | elements frozen until sigma_valid (or watchdog expiry)
module matrix_loader
    import matrix_pkg::*;
#(
    parameter int PRECISION = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PRECISION-1:0] s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    output logic [PRECISION-1:0] A00,
    output logic [PRECISION-1:0] A01,
    output logic [PRECISION-1:0] A02,
    output logic [PRECISION-1:0] A10,
    output logic [PRECISION-1:0] A11,
    output logic [PRECISION-1:0] A12,
    output logic [PRECISION-1:0] A20,
    output logic [PRECISION-1:0] A21,
    output logic [PRECISION-1:0] A22,
    output logic                 tvalid,
    input  logic                 sigma_valid,
    output logic                 busy,
`ifdef MATRIX_LOADER_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic                 frame_err
);

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("matrix_loader: TIMEOUT must be at least 1");
    end

    state_e               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [PRECISION-1:0] elem_q [N_ELEM];
    logic                 wr_en;
    logic                 s_tready_q, s_tready_d;
    logic                 tvalid_q, tvalid_d;
    logic                 busy_q, busy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 expired;

`ifdef MATRIX_LOADER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // Counter holds the number of WAIT cycles left after the current one.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == FIRE) begin
            cnt_d     = CNT_W'(TIMEOUT - 1);
            timeout_d = (TIMEOUT == 1);
        end else if (state_q == WAIT && !sigma_valid) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            timeout_d = (cnt_q == CNT_W'(1));
        end
    end

    assign expired = (cnt_q == '0);
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_en       = 1'b0;
        tvalid_d    = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (s_tvalid && s_tready_q) begin
                    wr_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d = 4'd0;
                        if (s_tlast) begin
                            state_d  = FIRE;
                            tvalid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else if (s_tlast) begin
                        idx_d       = 4'd0;
                        frame_err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            FIRE: state_d = WAIT;
            WAIT: begin
                if (sigma_valid || expired) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        // Flags are registered from the next state so they line up with it.
        s_tready_d = (state_d == LOAD);
        busy_d     = (state_d != LOAD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            idx_q       <= 4'd0;
            s_tready_q  <= 1'b0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            for (int k = 0; k < N_ELEM; k++) begin
                elem_q[k] <= '0;
            end
`ifdef MATRIX_LOADER_TIMEOUT_EN
            cnt_q       <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            s_tready_q  <= s_tready_d;
            tvalid_q    <= tvalid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            for (int k = 0; k < N_ELEM; k++) begin
                if (wr_en && idx_q == 4'(k)) begin
                    elem_q[k] <= s_tdata;
                end
            end
`ifdef MATRIX_LOADER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign s_tready  = s_tready_q;
    assign tvalid    = tvalid_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
`ifdef MATRIX_LOADER_TIMEOUT_EN
    assign timeout   = timeout_q;
`endif

    assign A00 = elem_q[0];
    assign A01 = elem_q[1];
    assign A02 = elem_q[2];
    assign A10 = elem_q[3];
    assign A11 = elem_q[4];
    assign A12 = elem_q[5];
    assign A20 = elem_q[6];
    assign A21 = elem_q[7];
    assign A22 = elem_q[8];

endmodule

// File: tb/tb_matrix_loader.sv
// Self-checking bench for matrix_loader: vector table, scoreboard of expected matrices, corner sequences.
module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] A00, A01, A02, A10, A11, A12, A20, A21, A22;
    logic        tvalid, sigma_valid, busy, frame_err;
`ifdef MATRIX_LOADER_TIMEOUT_EN
    logic        timeout;
`endif

    matrix_loader #(.PRECISION(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .A00(A00), .A01(A01), .A02(A02), .A10(A10), .A11(A11), .A12(A12),
        .A20(A20), .A21(A21), .A22(A22),
        .tvalid(tvalid), .sigma_valid(sigma_valid), .busy(busy),
`ifdef MATRIX_LOADER_TIMEOUT_EN
        .timeout(timeout),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] e [9]; } mat_s;
    typedef struct {
        logic [31:0] w [9];
        int          tlast_at;   // -1: no tlast at all
        bit          good;
    } vec_s;

    mat_s        exp_q [$];
    logic [31:0] a_obs [9];
    logic [31:0] held  [9];
    int          n_cmp = 0, n_bad = 0;
    int          n_tvalid = 0, n_ferr = 0;
    logic        prev_tv = 1'b0;

    assign a_obs[0] = A00; assign a_obs[1] = A01; assign a_obs[2] = A02;
    assign a_obs[3] = A10; assign a_obs[4] = A11; assign a_obs[5] = A12;
    assign a_obs[6] = A20; assign a_obs[7] = A21; assign a_obs[8] = A22;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Scoreboard: pop on every tvalid, and hold A stable while busy.
    always @(negedge clk) begin
        if (!reset) begin
            if (tvalid) begin
                mat_s m;
                n_tvalid++;
                check("tvalid_width", 32'(prev_tv), 32'd0);
                check("busy_fire", 32'(busy), 32'd1);
                if (exp_q.size() == 0) begin
                    fail("tvalid_unexpected");
                end else begin
                    m = exp_q.pop_front();
                    for (int k = 0; k < 9; k++) begin
                        check($sformatf("elem%0d", k), a_obs[k], m.e[k]);
                    end
                end
                for (int k = 0; k < 9; k++) held[k] = a_obs[k];
            end else if (busy) begin
                for (int k = 0; k < 9; k++) begin
                    if (a_obs[k] !== held[k]) check($sformatf("stable%0d", k), a_obs[k], held[k]);
                end
            end
            if (frame_err) n_ferr++;
            prev_tv = tvalid;
        end else begin
            prev_tv = 1'b0;
        end
    end

    task automatic finish_fatal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "bench stopped early");
    endtask

    // Called at posedge+1; returns at posedge+1 just after the last accept.
    task automatic send_words(input logic [31:0] w [9], input int n, input int tlast_at);
        for (int i = 0; i < n; i++) begin
            int b;
            s_tvalid = 1'b1;
            s_tdata  = w[i];
            s_tlast  = (i == tlast_at);
            b = 0;
            forever begin
                @(negedge clk);
                if (s_tready) break;
                b++;
                if (b > 60) begin
                    fail("accept_timeout");
                    finish_fatal();
                end
                @(posedge clk); #1;
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Called after the FIRE-cycle negedge; returns at posedge+1 of the second LOAD cycle.
    task automatic release_wait(input int delay);
        @(posedge clk); #1;
        repeat (delay) begin @(posedge clk); #1; end
        sigma_valid = 1'b1;
        @(posedge clk); #1;
        sigma_valid = 1'b0;
        @(negedge clk);
        check("ready_after_sigma", 32'(s_tready), 32'd1);
        check("busy_after_sigma", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic push_exp(input logic [31:0] w [9]);
        mat_s m;
        for (int k = 0; k < 9; k++) m.e[k] = w[k];
        exp_q.push_back(m);
    endtask

    vec_s        vecs [6];
    logic [31:0] wa [9], wb [9];
    int          t0;

    initial begin
        #200000;
        fail("global_watchdog");
        finish_fatal();
    end

    initial begin
        vecs[0].w = '{32'h0, 32'h3f000000, 32'h3d4ccccd, 32'h3eaaaaaa, 32'h0,
                      32'h3eaaaaaa, 32'h3d4ccccd, 32'h3f000000, 32'h0};
        vecs[0].tlast_at = 8; vecs[0].good = 1'b1;
        vecs[1].w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88, 32'h99};
        vecs[1].tlast_at = 4; vecs[1].good = 1'b0;
        vecs[2].w = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40a00000,
                      32'h40c00000, 32'h40e00000, 32'h41000000, 32'h41100000};
        vecs[2].tlast_at = 8; vecs[2].good = 1'b1;
        vecs[3].w = '{32'hdead0000, 32'hdead0001, 32'hdead0002, 32'hdead0003, 32'hdead0004,
                      32'hdead0005, 32'hdead0006, 32'hdead0007, 32'hdead0008};
        vecs[3].tlast_at = -1; vecs[3].good = 1'b0;
        vecs[4].w = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                      32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
        vecs[4].tlast_at = 8; vecs[4].good = 1'b1;
        vecs[5].w = '{32'hbf800000, 32'h00000001, 32'h80000000, 32'h7f800000, 32'h7fc00000,
                      32'h00800000, 32'h3c23d70a, 32'hc2c80000, 32'h5a5a5a5a};
        vecs[5].tlast_at = 8; vecs[5].good = 1'b1;

        reset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; sigma_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(s_tready), 32'd0);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_A00", A00, 32'd0);
        check("rst_A22", A22, 32'd0);
`ifdef MATRIX_LOADER_TIMEOUT_EN
        check("rst_timeout", 32'(timeout), 32'd0);
`endif
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after_rst", 32'(s_tready), 32'd1);
        @(posedge clk); #1;

        // sigma_valid in LOAD must not start anything
        sigma_valid = 1'b1;
        @(posedge clk); #1;
        sigma_valid = 1'b0;
        @(negedge clk);
        check("sigma_in_load_busy", 32'(busy), 32'd0);
        check("sigma_in_load_ready", 32'(s_tready), 32'd1);
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            t0 = n_ferr;
            if (vecs[v].good) push_exp(vecs[v].w);
            send_words(vecs[v].w, (vecs[v].tlast_at < 0) ? 9 : vecs[v].tlast_at + 1, vecs[v].tlast_at);
            @(negedge clk);
            check($sformatf("v%0d_tvalid", v), 32'(tvalid), 32'(vecs[v].good));
            check($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(!vecs[v].good));
            check($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].good));
            if (v == 0) begin
                check("v0_A01", A01, 32'h3f000000);
                check("v0_A12", A12, 32'h3eaaaaaa);
                check("v0_A20", A20, 32'h3d4ccccd);
            end
            if (vecs[v].good) begin
                release_wait(v);
            end else begin
                @(posedge clk); #1;
                @(negedge clk);
                check($sformatf("v%0d_ferr_pulse", v), 32'(frame_err), 32'd0);
                check($sformatf("v%0d_ferr_count", v), 32'(n_ferr - t0), 32'd1);
                check($sformatf("v%0d_ready", v), 32'(s_tready), 32'd1);
                @(posedge clk); #1;
            end
        end

        // s_tvalid held in WAIT for 20 cycles, sigma on the 20th
        wa = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9};
        push_exp(wa);
        send_words(wa, 9, 8);
        @(negedge clk);
        check("hold_tvalid", 32'(tvalid), 32'd1);
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = 32'hbadbad00; s_tlast = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 20) sigma_valid = 1'b1;
            @(negedge clk);
            check($sformatf("hold_ready_c%0d", c), 32'(s_tready), 32'd0);
            @(posedge clk); #1;
            sigma_valid = 1'b0;
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        check("hold_ready_c21", 32'(s_tready), 32'd1);
        check("hold_A11", A11, 32'h5);
        @(posedge clk); #1;

        // reset after 4 words discards the partial matrix
        wa = '{32'hcafe0000, 32'hcafe0001, 32'hcafe0002, 32'hcafe0003, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        send_words(wa, 4, -1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(s_tready), 32'd0);
        check("midrst_A01", A01, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        t0 = n_tvalid;
        wb = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80, 32'h90};
        push_exp(wb);
        send_words(wb, 9, 8);
        @(negedge clk);
        check("midrst_tvalid", 32'(tvalid), 32'd1);
        release_wait(2);
        check("midrst_one_tvalid", 32'(n_tvalid - t0), 32'd1);

        // back-to-back: sigma one cycle after tvalid, next frame waiting
        t0 = n_tvalid;
        wa = '{32'ha0, 32'ha1, 32'ha2, 32'ha3, 32'ha4, 32'ha5, 32'ha6, 32'ha7, 32'ha8};
        wb = '{32'hb0, 32'hb1, 32'hb2, 32'hb3, 32'hb4, 32'hb5, 32'hb6, 32'hb7, 32'hb8};
        push_exp(wa);
        push_exp(wb);
        send_words(wa, 9, 8);
        @(negedge clk);
        check("b2b_tvalid1", 32'(tvalid), 32'd1);
        @(posedge clk); #1;
        sigma_valid = 1'b1; s_tvalid = 1'b1; s_tdata = wb[0];
        @(negedge clk);
        check("b2b_ready_wait", 32'(s_tready), 32'd0);
        @(posedge clk); #1;
        sigma_valid = 1'b0;
        send_words(wb, 9, 8);
        @(negedge clk);
        check("b2b_tvalid2", 32'(tvalid), 32'd1);
        release_wait(0);
        check("b2b_count", 32'(n_tvalid - t0), 32'd2);

        // reset while in WAIT
        wa = '{32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0, 32'h9, 32'h8, 32'h7};
        push_exp(wa);
        send_words(wa, 9, 8);
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("waitrst_busy", 32'(busy), 32'd0);
        check("waitrst_A22", A22, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

`ifdef MATRIX_LOADER_TIMEOUT_EN
        wa = '{32'h71, 32'h72, 32'h73, 32'h74, 32'h75, 32'h76, 32'h77, 32'h78, 32'h79};
        push_exp(wa);
        send_words(wa, 9, 8);
        @(negedge clk);
        check("to_tvalid", 32'(tvalid), 32'd1);
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check($sformatf("to_pulse_c%0d", c), 32'(timeout), 32'(c == 16));
            check($sformatf("to_ready_c%0d", c), 32'(s_tready), 32'(c == 17));
        end
        @(posedge clk); #1;
`endif

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
